// File: rtl/spi_sram_responder.sv
// ============================================================================
// Module   : spi_sram_responder
// Purpose  : Serial SRAM target: 8-bit command, 24-bit address, 16-bit LSB-first
//            data words backed by an aliased internal byte array.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sram_responder #(
    parameter int ADDR_BITS = 8,
    parameter int MEM_BYTES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic sram_cs,
    input  logic sram_si,
    output logic sram_so,
    output logic busy,
    output logic frame_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_IGNORE = 3'd4
    } state_t;

    localparam logic [7:0]           c_cmd_read  = 8'h03;
    localparam logic [7:0]           c_cmd_write = 8'h02;
    localparam logic [5:0]           c_k_last_cmd  = 6'd7;
    localparam logic [5:0]           c_k_last_addr = 6'd31;
    localparam logic [5:0]           c_k_data_base = 6'd32;
    localparam logic [ADDR_BITS-1:0] c_one = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] c_two = ADDR_BITS'(2);

    state_t                 r_state;
    logic [5:0]             r_k;
    logic [6:0]             r_cmd;
    logic                   r_is_read;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [15:0]            r_word;
    logic [7:0]             r_mem [MEM_BYTES];

    logic [7:0]             w_cmd_byte;
    logic [ADDR_BITS-1:0]   w_addr_shift;
    logic [ADDR_BITS-1:0]   w_addr_next;
    logic [ADDR_BITS-1:0]   w_rd_base;
    logic [15:0]            w_rd_word;
    logic [15:0]            w_wr_word;
    logic                   w_word_end;
    logic                   w_commit;

    assign w_cmd_byte   = {r_cmd, sram_si};
    assign w_addr_shift = {r_addr[ADDR_BITS-2:0], sram_si};
    assign w_addr_next  = r_addr + c_two;
    assign w_word_end   = (r_k[3:0] == 4'hF);

    // The first read word is fetched at the last address bit, so the address
    // is taken straight from the shifter plus the live input bit.
    assign w_rd_base = (r_state == S_ADDR) ? w_addr_shift : w_addr_next;
    assign w_rd_word = {r_mem[w_rd_base + c_one], r_mem[w_rd_base]};
    assign w_wr_word = {sram_si, r_word[14:0]};

    assign w_commit = ena && !rst && !sram_cs && (r_state == S_DATA)
                      && !r_is_read && w_word_end;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_addr]         <= w_wr_word[7:0];
            r_mem[r_addr + c_one] <= w_wr_word[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= 6'd0;
            r_cmd       <= 7'd0;
            r_is_read   <= 1'b0;
            r_addr      <= '0;
            r_word      <= 16'd0;
            sram_so     <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (ena) begin
                if (sram_cs) begin
                    r_state <= S_IDLE;
                    r_k     <= 6'd0;
                    sram_so <= 1'b0;
                    busy    <= 1'b0;
                end else begin
                    busy <= 1'b1;
                    case (r_state)
                        S_IDLE: begin
                            r_cmd   <= {6'd0, sram_si};
                            r_k     <= 6'd1;
                            sram_so <= 1'b0;
                            r_state <= S_CMD;
                        end
                        S_CMD: begin
                            r_cmd <= {r_cmd[5:0], sram_si};
                            r_k   <= r_k + 6'd1;
                            if (r_k == c_k_last_cmd) begin
                                if (w_cmd_byte == c_cmd_read) begin
                                    r_is_read <= 1'b1;
                                    r_state   <= S_ADDR;
                                end else if (w_cmd_byte == c_cmd_write) begin
                                    r_is_read <= 1'b0;
                                    r_state   <= S_ADDR;
                                end else begin
                                    frame_error <= 1'b1;
                                    r_state     <= S_IGNORE;
                                end
                            end
                        end
                        S_ADDR: begin
                            r_addr <= w_addr_shift;
                            r_k    <= r_k + 6'd1;
                            if (r_k == c_k_last_addr) begin
                                r_state <= S_DATA;
                                if (r_is_read) begin
                                    r_word  <= w_rd_word;
                                    sram_so <= w_rd_word[0];
                                end else begin
                                    r_word <= 16'd0;
                                end
                            end
                        end
                        S_DATA: begin
                            if (w_word_end) begin
                                // Word boundary: advance two bytes; reads prefetch the next word.
                                r_k    <= c_k_data_base;
                                r_addr <= w_addr_next;
                                if (r_is_read) begin
                                    r_word  <= w_rd_word;
                                    sram_so <= w_rd_word[0];
                                end else begin
                                    r_word <= 16'd0;
                                end
                            end else begin
                                r_k <= r_k + 6'd1;
                                if (r_is_read) begin
                                    r_word  <= {1'b0, r_word[15:1]};
                                    sram_so <= r_word[1];
                                end else begin
                                    r_word[r_k[3:0]] <= sram_si;
                                end
                            end
                        end
                        S_IGNORE: begin
                            sram_so <= 1'b0;
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_k     <= 6'd0;
                            sram_so <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_sram_responder.sv
// ============================================================================
// Module   : tb_spi_sram_responder
// Purpose  : Randomised scoreboard bench for spi_sram_responder against a
//            byte-array reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_sram_responder;

    logic clk = 1'b0;
    logic rst, ena, sram_cs, sram_si;
    logic sram_so, busy, frame_error;

    spi_sram_responder #(.ADDR_BITS(8), .MEM_BYTES(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .sram_cs    (sram_cs),
        .sram_si    (sram_si),
        .sram_so    (sram_so),
        .busy       (busy),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_m [256];
    logic [15:0] exp_q [$];
    logic [15:0] wr_words [$];

    logic        rd_flag = 1'b0, zchk = 1'b0, hold_chk = 1'b0, hold_bit = 1'b0;
    logic        exp_busy = 1'b0, exp_ferr = 1'b0, last_cs_low = 1'b0;
    int          rd_cnt = 0;
    logic [15:0] rd_acc = 16'd0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples between edges and compares against bench expectations.
    always @(negedge clk) begin
        check("busy", {15'd0, busy}, {15'd0, exp_busy});
        check("frame_error", {15'd0, frame_error}, {15'd0, exp_ferr});
        if (zchk)     check("so_zero", {15'd0, sram_so}, 16'd0);
        if (hold_chk) check("so_hold", {15'd0, sram_so}, {15'd0, hold_bit});
        if (rd_flag) begin
            rd_acc[rd_cnt] = sram_so;
            rd_cnt++;
            if (rd_cnt == 16) begin
                rd_cnt = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_word: got %h expected none", rd_acc);
                end else begin
                    check("read_word", rd_acc, exp_q.pop_front());
                end
            end
        end
    end

    // One slot: inputs presented after an edge, sampled at the next edge.
    task automatic drive(input logic c, input logic s, input logic e,
                         input logic rf, input logic zc, input logic fe);
        @(posedge clk);
        #1;
        if (ena) last_cs_low = !sram_cs;
        exp_busy = last_cs_low;
        sram_cs  = c;
        sram_si  = s;
        ena      = e;
        rd_flag  = rf;
        zchk     = zc;
        exp_ferr = fe;
        hold_chk = 1'b0;
    endtask

    task automatic reset_mid;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sram_cs = 1'b1;
        ena = 1'b1;
        rd_flag = 1'b0;
        zchk = 1'b0;
        hold_chk = 1'b0;
        exp_busy = 1'b0;
        exp_ferr = 1'b0;
        last_cs_low = 1'b0;
        #1;
        check("rst_mid_busy", {15'd0, busy}, 16'd0);
        check("rst_mid_so", {15'd0, sram_so}, 16'd0);
        zchk = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [23:0] addr, input int nwords,
                         input int dbits, input int rst_k, input int gap_k);
        logic        is_rd, is_wr, bad, b;
        logic [7:0]  a;
        logic [15:0] tw;
        logic [15:0] exp_w [$];
        is_rd = (cmd == 8'h03);
        is_wr = (cmd == 8'h02);
        bad   = !is_rd && !is_wr;
        if (is_rd) begin
            for (int w = 0; w < nwords; w++) begin
                a  = addr[7:0] + 8'(2 * w);
                tw = {mem_m[a + 8'd1], mem_m[a]};
                exp_q.push_back(tw);
                exp_w.push_back(tw);
            end
        end
        for (int k = 0; k < 32 + dbits; k++) begin
            if (k == rst_k) begin
                reset_mid();
                return;
            end
            if (k == gap_k) begin
                tw = exp_w[(k - 32) / 16];
                repeat (5) begin
                    drive(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
                    hold_chk = 1'b1;
                    hold_bit = tw[(k - 32) % 16];
                end
            end
            if (k < 8)       b = cmd[7 - k];
            else if (k < 32) b = addr[31 - k];
            else if (is_wr) begin
                tw = wr_words[(k - 32) / 16];
                b  = tw[(k - 32) % 16];
            end else         b = 1'($urandom);
            drive(1'b0, b, 1'b1, is_rd && k >= 32, !is_rd || k <= 31, bad && k == 8);
            if (is_wr && k >= 32 && ((k - 32) % 16) == 15) begin
                tw = wr_words[(k - 32) / 16];
                a  = addr[7:0] + 8'(2 * ((k - 32) / 16));
                mem_m[a]        = tw[7:0];
                mem_m[a + 8'd1] = tw[15:8];
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, !is_rd, bad && (32 + dbits) == 8);
    endtask

    task automatic set_words(input int n);
        wr_words.delete();
        for (int i = 0; i < n; i++) wr_words.push_back(16'($urandom));
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n, r;

        rst = 1'b1; sram_cs = 1'b1; sram_si = 1'b0; ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_so", {15'd0, sram_so}, 16'd0);
        check("rst_ferr", {15'd0, frame_error}, 16'd0);
        rst = 1'b0;
        zchk = 1'b1;

        // Populate the whole memory so every later read has a known value.
        set_words(128);
        frame(8'h02, 24'h000000, 128, 2048, -1, -1);

        wr_words.delete(); wr_words.push_back(16'hBEEF);
        frame(8'h02, 24'h000010, 1, 16, -1, -1);
        frame(8'h03, 24'h000010, 1, 16, -1, -1);

        wr_words.delete(); wr_words.push_back(16'h1234);
        frame(8'h02, 24'h0000FF, 1, 16, -1, -1);
        frame(8'h03, 24'h0001FF, 1, 16, -1, -1);
        check("alias_model", {mem_m[8'h00], mem_m[8'hFF]}, 16'h1234);

        wr_words.delete(); wr_words.push_back(16'h1111); wr_words.push_back(16'h2222);
        frame(8'h02, 24'h000020, 2, 32, -1, -1);
        frame(8'h03, 24'h000020, 2, 32, -1, -1);

        frame(8'h05, 24'h000030, 0, 16, -1, -1);
        frame(8'h03, 24'h000030, 1, 16, -1, -1);

        set_words(1);
        frame(8'h02, 24'h000040, 1, 10, -1, -1);
        frame(8'h03, 24'h000040, 1, 16, -1, -1);

        set_words(1);
        frame(8'h02, 24'h000050, 1, 16, 40, -1);
        frame(8'h03, 24'h000050, 1, 16, -1, -1);

        frame(8'h03, 24'h000010, 1, 16, -1, 36);

        for (int t = 0; t < 30; t++) begin
            r    = int'($urandom_range(0, 9));
            addr = 24'($urandom);
            n    = int'($urandom_range(1, 3));
            set_words(n);
            if (r < 4)      frame(8'h02, addr, n, 16 * n, -1, -1);
            else if (r < 8) frame(8'h03, addr, n, 16 * n, -1,
                                  (r == 7) ? 32 + int'($urandom_range(1, 15)) : -1);
            else if (r < 9) begin
                do cmd = 8'($urandom); while (cmd == 8'h02 || cmd == 8'h03);
                frame(cmd, addr, 0, int'($urandom_range(0, 20)), -1, -1);
            end else        frame(8'h02, addr, n, int'($urandom_range(1, 15)), -1, -1);
        end

        repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("leftover_exp", 16'(exp_q.size()), 16'd0);
        check("leftover_bits", 16'(rd_cnt), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
